// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: FSM states, key length
// encodings, round counts and the key-length to round-count mapping.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // The illegal encoding 2'b11 falls back to the AES-128 round count.
    function automatic int nr_of(input logic [1:0] key_len);
        case (key_len)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Sub-cycle counter for the round sequencer. Counts the cycles spent inside
// one round and raises tick_o on the last of them; it is held at zero
// whenever the sequencer is not running rounds or is being flushed.
module aes_round_timer #(
    parameter int CYCLES_PER_ROUND = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_ROUND - 1);

    logic [CW-1:0] sub_q;
    logic [CW-1:0] sub_d;

    assign tick_o = run_i && (sub_q == LAST);

    // Next sub-count: wrap only through the tick, otherwise count up or clear.
    always_comb begin
        sub_d = sub_q;
        if (clear_i || !run_i) begin
            sub_d = '0;
        end else if (tick_o) begin
            sub_d = '0;
        end else begin
            sub_d = sub_q + CW'(1);
        end
    end

    // Sub-count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: accepts one block per handshake, runs 10/12/14 rounds
// chosen by key_len, then holds the result until the consumer takes it.
// Optional block counter output enabled by defining AES_ROUND_SEQ_BLKCNT_EN.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int CYCLES_PER_ROUND = 2,
    parameter int MAX_ROUNDS       = 14,
    parameter int ROUND_W          = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         key_len,
    input  logic               abort,
    output logic               load,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               final_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               key_err
`ifdef AES_ROUND_SEQ_BLKCNT_EN
    ,
    output logic [31:0]        blk_count
`endif
);

    state_t             state_q;
    logic [ROUND_W-1:0] n_q;
    logic [ROUND_W-1:0] idx_q;
    logic               key_err_q;
    logic [ROUND_W-1:0] n_sel;
    int                 nr_raw;
    logic               accept;
    logic               tick;

    aes_round_timer #(
        .CYCLES_PER_ROUND(CYCLES_PER_ROUND)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (state_q == ROUND),
        .clear_i(abort),
        .tick_o (tick)
    );

    // in_ready is forced low while reset is held so nothing is offered early.
    assign in_ready    = rst_n && (state_q == IDLE) && !abort;
    assign accept      = in_valid && in_ready;
    assign load        = accept;
    assign round_en    = tick;
    assign round_idx   = idx_q;
    assign final_round = (state_q == ROUND) && (idx_q == n_q);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign key_err     = key_err_q;

    // Round count for the offered key length, clamped to what round_idx can hold.
    always_comb begin
        nr_raw = nr_of(key_len);
        if (nr_raw > MAX_ROUNDS) begin
            nr_raw = MAX_ROUNDS;
        end
        n_sel = ROUND_W'(nr_raw);
    end

    // Main sequencer FSM; abort overrides every state and clears the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                n_q     <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            n_q       <= n_sel;
                            idx_q     <= ROUND_W'(1);
                            key_err_q <= (key_len == 2'b11);
                            state_q   <= ROUND;
                        end
                    end
                    ROUND: begin
                        if (tick) begin
                            if (idx_q == n_q) begin
                                idx_q   <= '0;
                                state_q <= DONE;
                            end else begin
                                idx_q <= idx_q + ROUND_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef AES_ROUND_SEQ_BLKCNT_EN
    logic [31:0] blk_q;

    assign blk_count = blk_q;

    // Completed-result counter; a result discarded by abort is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else if ((state_q == DONE) && out_ready && !abort) begin
            blk_q <= blk_q + 32'd1;
        end
    end
`endif

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Parametrised AES round sequencer; successor to the fixed-latency encryptor controller.
- Accepts one block per valid/ready handshake and selects 10, 12 or 14 rounds at run time from the key length.
- Produces per-round datapath strobes, then holds the result under output backpressure.
- Sits between the host-side stream interface and the round datapath / key-expansion unit.

Parameters:
- CYCLES_PER_ROUND, 2, clock cycles each round occupies (>=1).
- MAX_ROUNDS, 14, upper bound on rounds; sizes round_idx.
- ROUND_W, $clog2(MAX_ROUNDS+1), width of round_idx (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  sequencer can accept a block
- key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal; sampled on accept
- abort  in  1  synchronous flush
- load  out  1  datapath captures plaintext/key this cycle
- round_en  out  1  datapath advances one round this cycle
- round_idx  out  ROUND_W  current round, 1..N; 0 when not in ROUND
- final_round  out  1  current round is round N (skip MixColumns)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- busy  out  1  block in flight (ROUND or DONE)
- key_err  out  1  one-cycle pulse when key_len=11 is accepted

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in IDLE. load, round_en, out_valid, busy, key_err, final_round = 0. round_idx=0. Internal state=IDLE, counters=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = !abort.
  - Accept when in_valid && in_ready. load is combinational, high in the accept cycle.
  - On accept, latch N: 10/12/14 for key_len 00/01/10.
  - key_len=11 latches N=10 and pulses key_err on the cycle after accept.
  - Next state is ROUND with round_idx=1 and sub-counter=0.
- ROUND:
  - sub-counter counts 0..CYCLES_PER_ROUND-1.
  - round_en is high when sub-counter = CYCLES_PER_ROUND-1; on that cycle round_idx increments and sub-counter wraps to 0.
  - final_round = (round_idx==N).
  - round_en on round N moves to DONE.
- DONE:
  - out_valid=1, held stable until out_valid && out_ready; then go to IDLE.
  - No new accept in the same cycle; in_ready rises the next cycle.
- Latency: accept at cycle T. round_en fires at T+k*C for k=1..N, where C=CYCLES_PER_ROUND. out_valid rises at T+N*C+1.
  - Defaults, AES-128: out_valid at T+21.
- busy = state != IDLE.
- abort: in any state, the next cycle is IDLE with all strobes 0 and counters cleared.
  - abort in the DONE cycle where out_ready=1 discards the result; no handshake is counted.
  - abort suppresses acceptance in IDLE.
- Parameter check: if MAX_ROUNDS<14, key_len values needing more rounds clamp N to MAX_ROUNDS.
- Reset mid-operation: immediate return to reset values; no partial out_valid.
- round_idx never exceeds N. The sub-counter wraps only through the round_en path.

Optional Feature:
- Macro AES_ROUND_SEQ_BLKCNT_EN adds output blk_count [31:0]:
  - Increments on each completed out_valid && out_ready handshake; wraps 0xFFFFFFFF->0.
  - Clears on reset; unaffected by abort.
- Without the macro, the port and counter are absent and all other behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - state enum {IDLE, ROUND, DONE}
  - key_len encodings KL_128/KL_192/KL_256
  - round counts NR_128=10, NR_192=12, NR_256=14
  - function nr_of(key_len)
- One sub-module, aes_round_timer: the sub-cycle counter producing the round_en tick. Everything else is in one FSM.

Test Plan:
- key_len=00, out_ready=1, accept at T -> round_en at T+2,4,...,20; final_round with round_idx=10; out_valid at T+21; in_ready at T+22.
- key_len=10 -> 14 round_en pulses; out_valid at T+29; round_idx reaches 14 exactly once.
- out_ready=0 for 5 cycles after out_valid -> out_valid stays high, in_ready stays 0; completes when out_ready=1.
- abort asserted at round 5 -> IDLE the next cycle; no out_valid; the next block completes normally in 21 cycles.
- key_len=11 accepted -> key_err pulses once; 10 rounds run. rst_n low mid-ROUND -> all outputs return to reset values at once.
- CYCLES_PER_ROUND=1 and the BLKCNT macro on; 3 back-to-back blocks -> out_valid at T+11 for each; blk_count=3.
